// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the CPU pipeline
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle between the execute stage and its ALU
interface alu_if;
  import cpu_types_pkg::*;
  word_t  a;
  word_t  b;
  word_t  result;
  aluop_t op;
  logic   zero;
  logic   overflow;
  modport alu (input a, b, op, output result, zero, overflow);
  modport ex (output a, b, op, input result, zero, overflow);
endinterface

// File: rtl/alu.sv
// alu: combinational 32-bit ALU; unknown opcodes yield result 0, overflow 0
module alu
  import cpu_types_pkg::*;
(
  alu_if.alu aif
);
  word_t sum, diff, res;
  logic  ovf;
  assign sum  = aif.a + aif.b;
  assign diff = aif.a - aif.b;
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (aif.op)
      ALU_SLL:  res = aif.b << aif.a[4:0];
      ALU_SRL:  res = aif.b >> aif.a[4:0];
      ALU_ADD: begin
        res = sum;
        ovf = (aif.a[31] == aif.b[31]) && (sum[31] != aif.a[31]);
      end
      ALU_SUB: begin
        res = diff;
        ovf = (aif.a[31] != aif.b[31]) && (diff[31] != aif.a[31]);
      end
      ALU_AND:  res = aif.a & aif.b;
      ALU_OR:   res = aif.a | aif.b;
      ALU_XOR:  res = aif.a ^ aif.b;
      ALU_NOR:  res = ~(aif.a | aif.b);
      ALU_SLT:  res = {31'b0, $signed(aif.a) < $signed(aif.b)};
      ALU_SLTU: res = {31'b0, aif.a < aif.b};
      default:  ;
    endcase
  end
  assign aif.result   = res;
  assign aif.zero     = (res == '0);
  assign aif.overflow = ovf;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: ID/EX and EX/MEM pipeline registers with operand forwarding around the ALU
module ex_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        en,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [3:0]  id_aluop,
  input  logic [31:0] id_rdat1,
  input  logic [31:0] id_rdat2,
  input  logic [31:0] id_imm,
  input  logic        id_alusrc,
  input  logic        id_shift,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_wsel,
  input  logic        id_regwen,
  input  logic [4:0]  wb_wsel,
  input  logic        wb_regwen,
  input  logic [31:0] wb_wdat,
  output logic        ex_valid,
  output logic [31:0] ex_result,
  output logic [31:0] ex_stdata,
  output logic [4:0]  ex_wsel,
  output logic        ex_regwen,
  output logic        ex_zero,
  output logic        ex_overflow
);
  typedef struct packed {
    logic       valid;
    logic [3:0] aluop;
    word_t      rdat1;
    word_t      rdat2;
    word_t      imm;
    logic       alusrc;
    logic       shift;
    regbits_t   shamt;
    regbits_t   rs;
    regbits_t   rt;
    regbits_t   wsel;
    logic       regwen;
  } idex_t;
  typedef struct packed {
    logic     valid;
    word_t    result;
    word_t    stdata;
    regbits_t wsel;
    logic     regwen;
    logic     zero;
    logic     overflow;
  } exmem_t;
  idex_t  idex_q, idex_d;
  exmem_t exmem_q, exmem_d;
  word_t  rs_fwd, rt_fwd;
  alu_if aif ();
  alu u_alu (.aif(aif));
  // EX/MEM outranks WB; r0 is never forwarded
  assign rs_fwd = (exmem_q.valid && exmem_q.regwen && exmem_q.wsel == idex_q.rs && idex_q.rs != '0) ? exmem_q.result :
                  (wb_regwen && wb_wsel == idex_q.rs && idex_q.rs != '0) ? wb_wdat : idex_q.rdat1;
  assign rt_fwd = (exmem_q.valid && exmem_q.regwen && exmem_q.wsel == idex_q.rt && idex_q.rt != '0) ? exmem_q.result :
                  (wb_regwen && wb_wsel == idex_q.rt && idex_q.rt != '0) ? wb_wdat : idex_q.rdat2;
  assign aif.a  = idex_q.shift ? {27'b0, idex_q.shamt} : rs_fwd;
  assign aif.b  = idex_q.alusrc ? idex_q.imm : rt_fwd;
  assign aif.op = aluop_t'(idex_q.aluop);
  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    if (en) begin
      idex_d  = '{valid: id_valid & ~flush, aluop: id_aluop, rdat1: id_rdat1, rdat2: id_rdat2,
                  imm: id_imm, alusrc: id_alusrc, shift: id_shift, shamt: id_shamt, rs: id_rs,
                  rt: id_rt, wsel: id_wsel, regwen: id_regwen};
      exmem_d = '{valid: idex_q.valid, result: aif.result, stdata: rt_fwd, wsel: idex_q.wsel,
                  regwen: idex_q.regwen & idex_q.valid, zero: aif.zero, overflow: aif.overflow};
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end
  assign ex_valid    = exmem_q.valid;
  assign ex_result   = exmem_q.result;
  assign ex_stdata   = exmem_q.stdata;
  assign ex_wsel     = exmem_q.wsel;
  assign ex_regwen   = exmem_q.regwen;
  assign ex_zero     = exmem_q.zero;
  assign ex_overflow = exmem_q.overflow;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and random stimulus against a behavioural two-stage pipeline model
module tb_ex_stage;
  import cpu_types_pkg::*;
  logic        CLK = 0, nRST = 0, en = 0, flush = 0, id_valid = 0;
  logic [3:0]  id_aluop = 0;
  logic [31:0] id_rdat1 = 0, id_rdat2 = 0, id_imm = 0, wb_wdat = 0;
  logic        id_alusrc = 0, id_shift = 0, id_regwen = 0, wb_regwen = 0;
  logic [4:0]  id_shamt = 0, id_rs = 0, id_rt = 0, id_wsel = 0, wb_wsel = 0;
  logic        ex_valid, ex_regwen, ex_zero, ex_overflow;
  logic [31:0] ex_result, ex_stdata;
  logic [4:0]  ex_wsel;
  int checks = 0, failures = 0;

  ex_stage dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .id_valid(id_valid), .id_aluop(id_aluop),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm), .id_alusrc(id_alusrc),
    .id_shift(id_shift), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
    .id_regwen(id_regwen), .wb_wsel(wb_wsel), .wb_regwen(wb_regwen), .wb_wdat(wb_wdat),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_stdata(ex_stdata), .ex_wsel(ex_wsel),
    .ex_regwen(ex_regwen), .ex_zero(ex_zero), .ex_overflow(ex_overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic valid; logic [3:0] op; word_t r1, r2, imm;
    logic alusrc, shift; logic [4:0] shamt, rs, rt, wsel; logic regwen;
  } id_t;
  typedef struct {
    logic valid; word_t result, stdata; logic [4:0] wsel; logic regwen, zero, ovf;
  } ex_t;
  id_t m_id;
  ex_t m_ex;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic word_t ref_alu(logic [3:0] op, word_t a, word_t b, output logic ovf);
    longint s;
    ovf = 1'b0;
    case (op)
      ALU_SLL:  return b << a[4:0];
      ALU_SRL:  return b >> a[4:0];
      ALU_ADD: begin
        s = longint'($signed(a)) + longint'($signed(b));
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return word_t'(s);
      end
      ALU_SUB: begin
        s = longint'($signed(a)) - longint'($signed(b));
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return word_t'(s);
      end
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      ALU_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic word_t fwd(logic [4:0] r, word_t dat);
    if (r == 0) return dat;
    if (m_ex.valid && m_ex.regwen && m_ex.wsel == r) return m_ex.result;
    if (wb_regwen && wb_wsel == r) return wb_wdat;
    return dat;
  endfunction

  task automatic model_clear();
    m_id = '{valid: 0, op: 0, r1: 0, r2: 0, imm: 0, alusrc: 0, shift: 0, shamt: 0, rs: 0, rt: 0, wsel: 0, regwen: 0};
    m_ex = '{valid: 0, result: 0, stdata: 0, wsel: 0, regwen: 0, zero: 0, ovf: 0};
  endtask

  task automatic compare();
    check("ex_valid", ex_valid, m_ex.valid);
    check("ex_regwen", ex_regwen, m_ex.regwen);
    if (m_ex.valid) begin
      check("ex_result", ex_result, m_ex.result);
      check("ex_stdata", ex_stdata, m_ex.stdata);
      check("ex_wsel", ex_wsel, m_ex.wsel);
      check("ex_zero", ex_zero, m_ex.zero);
      check("ex_overflow", ex_overflow, m_ex.ovf);
    end
  endtask

  task automatic tick();
    ex_t nx;
    id_t ni;
    word_t a, b, rsf, rtf, r;
    logic o;
    nx = m_ex;
    ni = m_id;
    if (en) begin
      rsf = fwd(m_id.rs, m_id.r1);
      rtf = fwd(m_id.rt, m_id.r2);
      a = m_id.shift ? {27'd0, m_id.shamt} : rsf;
      b = m_id.alusrc ? m_id.imm : rtf;
      r = ref_alu(m_id.op, a, b, o);
      nx = '{valid: m_id.valid, result: r, stdata: rtf, wsel: m_id.wsel,
             regwen: m_id.regwen & m_id.valid, zero: (r == 0), ovf: o};
      ni = '{valid: id_valid & ~flush, op: id_aluop, r1: id_rdat1, r2: id_rdat2, imm: id_imm,
             alusrc: id_alusrc, shift: id_shift, shamt: id_shamt, rs: id_rs, rt: id_rt,
             wsel: id_wsel, regwen: id_regwen};
    end
    @(posedge CLK);
    #1;
    m_ex = nx;
    m_id = ni;
    compare();
  endtask

  task automatic issue(logic [3:0] op, word_t r1, word_t r2, word_t imm, logic alusrc, logic shift,
                       logic [4:0] shamt, logic [4:0] rs, logic [4:0] rt, logic [4:0] wsel);
    id_valid = 1; id_aluop = op; id_rdat1 = r1; id_rdat2 = r2; id_imm = imm;
    id_alusrc = alusrc; id_shift = shift; id_shamt = shamt; id_rs = rs; id_rt = rt;
    id_wsel = wsel; id_regwen = 1;
  endtask

  task automatic idle();
    id_valid = 0;
  endtask

  task automatic reset_pulse();
    #2 nRST = 0;
    #1;
    check("arst_valid", ex_valid, 0);
    check("arst_result", ex_result, 0);
    check("arst_stdata", ex_stdata, 0);
    check("arst_wsel", ex_wsel, 0);
    check("arst_regwen", ex_regwen, 0);
    check("arst_zero", ex_zero, 0);
    check("arst_ovf", ex_overflow, 0);
    model_clear();
    #1 nRST = 1;
  endtask

  initial begin
    model_clear();
    #12;
    check("rst_valid", ex_valid, 0);
    check("rst_result", ex_result, 0);
    check("rst_regwen", ex_regwen, 0);
    check("rst_ovf", ex_overflow, 0);
    @(negedge CLK);
    nRST = 1;
    en = 1;
    // signed overflow on ADD
    issue(ALU_ADD, 32'h7fffffff, 0, 1, 1, 0, 0, 0, 0, 3); tick();
    idle(); tick();
    check("add_ovf_res", ex_result, 32'h80000000);
    check("add_ovf_flag", ex_overflow, 1);
    check("add_ovf_zero", ex_zero, 0);
    check("add_ovf_wsel", ex_wsel, 3);
    // back-to-back dependency through EX/MEM
    issue(ALU_ADD, 0, 0, 5, 1, 0, 0, 0, 0, 2); tick();
    issue(ALU_SUB, 0, 0, 0, 0, 0, 0, 2, 2, 4); tick();
    idle(); tick();
    check("sub_fwd_res", ex_result, 0);
    check("sub_fwd_zero", ex_zero, 1);
    issue(ALU_ADD, 0, 0, 5, 1, 0, 0, 0, 0, 2); tick();
    issue(ALU_ADD, 0, 0, 1, 1, 0, 0, 2, 0, 6); tick();
    idle(); tick();
    check("add_fwd_res", ex_result, 6);
    // EX/MEM beats WB
    issue(ALU_ADD, 0, 0, 32'h20, 1, 0, 0, 0, 0, 5); tick();
    issue(ALU_OR, 0, 0, 0, 1, 0, 0, 5, 0, 6);
    wb_regwen = 1; wb_wsel = 5; wb_wdat = 32'h10; tick();
    idle(); tick();
    check("prio_ex", ex_result, 32'h20);
    issue(ALU_OR, 0, 0, 0, 1, 0, 0, 5, 0, 7); tick();
    idle(); tick();
    check("prio_wb", ex_result, 32'h10);
    wb_wsel = 0;
    issue(ALU_OR, 32'h33, 0, 0, 1, 0, 0, 0, 0, 8); tick();
    idle(); tick();
    check("r0_nofwd", ex_result, 32'h33);
    wb_regwen = 0;
    // shift and compares
    issue(ALU_SLL, 0, 1, 0, 0, 1, 4, 0, 0, 9); tick();
    idle(); tick();
    check("sll", ex_result, 32'h10);
    issue(ALU_SLT, 32'hffffffff, 1, 0, 0, 0, 0, 0, 0, 9); tick();
    idle(); tick();
    check("slt", ex_result, 1);
    issue(ALU_SLTU, 32'hffffffff, 1, 0, 0, 0, 0, 0, 0, 9); tick();
    idle(); tick();
    check("sltu", ex_result, 0);
    // stall freezes both registers
    issue(ALU_ADD, 0, 0, 7, 1, 0, 0, 0, 0, 1); tick();
    issue(ALU_ADD, 0, 0, 9, 1, 0, 0, 0, 0, 1); tick();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", ex_result, 7);
    end
    en = 1; idle(); tick();
    check("stall_adv", ex_result, 9);
    // flush squashes the entering instruction
    issue(ALU_ADD, 0, 0, 3, 1, 0, 0, 0, 0, 1); flush = 1; tick();
    flush = 0; idle(); tick();
    check("flush_valid", ex_valid, 0);
    check("flush_regwen", ex_regwen, 0);
    issue(ALU_ADD, 0, 0, 4, 1, 0, 0, 0, 0, 1); tick();
    en = 0; flush = 1; idle(); tick();
    en = 1; flush = 0; tick();
    check("flush_noen", ex_valid, 1);
    // async reset mid-stream, overriding stall and flush
    issue(ALU_XOR, 32'h5a5a, 32'h0f0f, 0, 0, 0, 0, 0, 0, 2); tick(); tick();
    en = 0; flush = 1;
    reset_pulse();
    en = 1; flush = 0;
    issue(ALU_ADD, 0, 0, 11, 1, 0, 0, 0, 0, 3); tick();
    idle(); tick();
    check("post_rst", ex_result, 11);
    // randomized traffic with heavy register-number aliasing
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_aluop = 4'($urandom_range(0, 11));
      id_rdat1 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8));
      id_rdat2 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8));
      id_imm = $urandom;
      id_alusrc = 1'($urandom);
      id_shift = ($urandom_range(0, 5) == 0);
      id_shamt = 5'($urandom);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_wsel = 5'($urandom_range(0, 3));
      id_regwen = 1'($urandom);
      wb_regwen = 1'($urandom);
      wb_wsel = 5'($urandom_range(0, 3));
      wb_wdat = $urandom;
      tick();
      if ($urandom_range(0, 99) == 0) reset_pulse();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL expose: CLK  in  1  single clock; all state on rising edge.
REQ-002 SHALL expose: nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL expose: en  in  1  pipeline advance; both stage registers load only when 1.
REQ-004 SHALL expose: flush  in  1  squash instruction entering ID/EX.
REQ-005 SHALL expose: id_valid  in  1  decode slot holds an instruction.
REQ-006 SHALL expose: id_aluop  in  4  ALU operation, aluop_t.
REQ-007 SHALL expose: id_rdat1, id_rdat2  in  32 each  register-file rs/rt data.
REQ-008 SHALL expose: id_imm  in  32  extended immediate.
REQ-009 SHALL expose: id_alusrc  in  1  1 = port b takes imm, 0 = forwarded rt.
REQ-010 SHALL expose: id_shift  in  1  1 = port a takes zero-extended id_shamt.
REQ-011 SHALL expose: id_shamt  in  5  shift amount.
REQ-012 SHALL expose: id_rs, id_rt, id_wsel  in  5 each  source and destination register numbers.
REQ-013 SHALL expose: id_regwen  in  1  instruction writes a register.
REQ-014 SHALL expose: wb_wsel  in  5, wb_regwen  in  1, wb_wdat  in  32  writeback-stage forwarding source.
REQ-015 SHALL expose: ex_valid  out  1, ex_result  out  32, ex_stdata  out  32, ex_wsel  out  5, ex_regwen  out  1, ex_zero  out  1, ex_overflow  out  1  EX/MEM register contents.

Function
REQ-016 SHALL hold two registers: ID/EX (all id_* fields) and EX/MEM (all ex_* outputs); latency id_* -> ex_* is exactly 2 enabled cycles.
REQ-017 On rising CLK with en=1, ID/EX SHALL load id_* with valid = id_valid & ~flush; with en=0 both registers SHALL hold.
REQ-018 flush with en=0 SHALL have no effect; flush never clears EX/MEM.
REQ-019 Forwarded rs operand SHALL be: ex_result if ex_valid & ex_regwen & ex_wsel==ID/EX rs & rs!=0; else wb_wdat if wb_regwen & wb_wsel==rs & rs!=0; else latched rdat1. EX/MEM SHALL have priority over WB.
REQ-020 Forwarded rt operand SHALL use the same rule on rt/rdat2.
REQ-021 ALU port a SHALL be {27'b0, shamt} when shift=1, else forwarded rs; port b SHALL be imm when alusrc=1, else forwarded rt.
REQ-022 ALU semantics SHALL be: SLL/SRL shift port b by port a[4:0]; ADD/SUB two's-complement, 32-bit wrap, signed overflow flag; AND/OR/XOR/NOR bitwise; SLT signed and SLTU unsigned compare yielding 0 or 1; undefined aluop yields result 0, overflow 0.
REQ-023 On en=1, EX/MEM SHALL load result, zero, overflow, forwarded rt (ex_stdata), wsel, and valid; regwen SHALL be ID/EX regwen & ID/EX valid.
REQ-024 An invalid ID/EX entry SHALL produce ex_valid=0 and ex_regwen=0; other ex_* fields are don't-care but deterministic.
REQ-025 ex_overflow SHALL be reported only; no trap or squash is generated by this block.
REQ-026 Forwarding SHALL be evaluated every cycle from current register contents, so a stall (en=0) followed by en=1 uses fresh wb_* values.

Reset
REQ-027 nRST=0 SHALL asynchronously clear both registers: every ex_* output 0, ID/EX valid 0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL override en and flush; first enabled edge after release loads normally.

Structure
REQ-029 aluop_t, word_t, regbits_t SHALL come from cpu_types_pkg; no new package types needed.
REQ-030 Arithmetic SHALL be a separate combinational sub-module alu through alu_if; ex_stage contains registers and forwarding muxes only.

Verification
REQ-031 ADD r3 <- 0x7FFFFFFF + 1 (alusrc=1): after 2 enabled edges ex_result=0x80000000, ex_overflow=1, ex_zero=0, ex_wsel=3.
REQ-032 Back-to-back ADD r2 <- r0+5 then SUB r4 <- r2-r2, rdat stale 0: second gives ex_result=0, ex_zero=1 (EX/MEM forward).
REQ-033 wb_regwen=1, wb_wsel=5, wb_wdat=0x10 and ex_wsel=5 ex_result=0x20 both matching rs=5, OR with imm 0: ex_result=0x20 (priority); rs=0 with wb_wsel=0: rdat1 used.
REQ-034 SLL shamt=4, rt data 0x1: ex_result=0x10; SLT -1<1 ->1, SLTU 0xFFFFFFFF<1 ->0.
REQ-035 en=0 for 3 cycles then en=1: outputs frozen then advance; flush=1 with en=1: next ex_valid=0, ex_regwen=0.
REQ-036 nRST pulsed low between edges mid-stream: all ex_* read 0 immediately, before next CLK edge.
